// File: rtl/segled_bcd_conv.sv
// segled_bcd_conv: serial binary-to-BCD converter using shift-add-3 (double dabble).
// It accepts one value per handshake, converts one bit per clock, and presents
// four registered BCD digits plus a leading-zero blank mask to the scan stage.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for in_valid; in_ready high
// S_CONV | one add-3 + shift per clock, BIN_W clocks in total
// S_DONE | publish digits/blank/ovf and pulse out_valid
module segled_bcd_conv #(
    parameter int BIN_W = 14
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [BIN_W-1:0] bin_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      bcd_data,
    output logic             out_valid,
    output logic [3:0]       blank,
    output logic             ovf
);

    localparam int                 CNT_W    = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [31:0]        MAX_DEC  = 32'd9999;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [BIN_W-1:0] r_sr;
    logic [15:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_flag;
    logic [15:0]      r_bcd;
    logic [3:0]       r_blank;
    logic             r_ovf;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_too_big;
    logic [BIN_W-1:0] w_load;
    logic [15:0]      w_adj;

    assign w_accept  = in_valid && (r_state == S_IDLE);
    // Widths below 14 cannot exceed 9999, so the compare folds to zero there.
    assign w_too_big = ({{(32-BIN_W){1'b0}}, bin_data} > MAX_DEC);
    assign w_load    = w_too_big ? MAX_DEC[BIN_W-1:0] : bin_data;

    // Add 3 to every accumulator nibble that is 5 or more, before the shift.
    always_comb begin
        w_adj = r_acc;
        for (int n = 0; n < 4; n++) begin
            if (r_acc[n*4 +: 4] >= 4'd5)
                w_adj[n*4 +: 4] = r_acc[n*4 +: 4] + 4'd3;
        end
    end

    // Conversion FSM and registered outputs; reset discards any conversion in flight.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_sr        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf_flag  <= 1'b0;
            r_bcd       <= 16'h0000;
            r_blank     <= 4'b1110;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sr       <= w_load;
                        r_ovf_flag <= w_too_big;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_acc <= {w_adj[14:0], r_sr[BIN_W-1]};
                    r_sr  <= {r_sr[BIN_W-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_bcd       <= r_acc;
                    r_blank[3]  <= (r_acc[15:12] == 4'd0);
                    r_blank[2]  <= (r_acc[15:12] == 4'd0) && (r_acc[11:8] == 4'd0);
                    r_blank[1]  <= (r_acc[15:12] == 4'd0) && (r_acc[11:8] == 4'd0)
                                   && (r_acc[7:4] == 4'd0);
                    r_blank[0]  <= 1'b0;
                    r_ovf       <= r_ovf_flag;
                    r_out_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign bcd_data  = r_bcd;
    assign blank     = r_blank;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_segled_bcd_conv.sv
// Testbench for segled_bcd_conv: directed cases from the block's intended use
// plus random values, all checked against a decimal reference model.
module tb_segled_bcd_conv;

    localparam int BIN_W = 14;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic [BIN_W-1:0] bin_data;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      bcd_data;
    logic             out_valid;
    logic [3:0]       blank;
    logic             ovf;

    int n_tests = 0;
    int n_fail  = 0;

    segled_bcd_conv #(.BIN_W(BIN_W)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .bin_data (bin_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bcd_data (bcd_data),
        .out_valid(out_valid),
        .blank    (blank),
        .ovf      (ovf)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: decimal digits by division, saturating at 9999.
    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [3:0] ref_blank(input int v);
        int s;
        logic [3:0] b;
        s = (v > 9999) ? 9999 : v;
        b = 4'b0000;
        if (s < 1000) b[3] = 1'b1;
        if (s < 100)  b[2] = 1'b1;
        if (s < 10)   b[1] = 1'b1;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < 40) begin
            step();
            k++;
        end
        if (k >= 40) chk("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Steps until out_valid is seen, returning clocks since the accept edge.
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic chk_result(input string tag, input int v);
        chk({tag, "_bcd"},   32'(bcd_data), 32'(ref_bcd(v)));
        chk({tag, "_blank"}, 32'(blank),    32'(ref_blank(v)));
        chk({tag, "_ovf"},   32'(ovf),      32'(v > 9999));
    endtask

    // Counts out_valid pulses over n cycles; expected to be zero.
    task automatic watch_quiet(input string tag, input int n);
        int p;
        p = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (out_valid) p++;
        end
        chk(tag, 32'(p), 32'd0);
    endtask

    task automatic run_one(input string tag, input int v);
        int lat;
        wait_ready();
        bin_data = BIN_W'(v);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd15);
        chk_result(tag, v);
        step();
        chk({tag, "_pulse1"}, 32'(out_valid), 32'd0);
        chk({tag, "_hold"},   32'(bcd_data),  32'(ref_bcd(v)));
    endtask

    initial begin
        int lat;
        int v;
        sys_rst  = 1'b1;
        in_valid = 1'b0;
        bin_data = '0;
        repeat (3) step();
        sys_rst = 1'b0;
        chk("rst_bcd",   32'(bcd_data),  32'h0);
        chk("rst_blank", 32'(blank),     32'b1110);
        chk("rst_ovf",   32'(ovf),       32'd0);
        chk("rst_ovld",  32'(out_valid), 32'd0);
        chk("rst_rdy",   32'(in_ready),  32'd1);

        run_one("zero", 0);
        run_one("v1234", 1234);
        run_one("v7", 7);
        run_one("v305", 305);
        run_one("v9999", 9999);
        run_one("sat10000", 10000);
        run_one("sat16383", 16383);
        run_one("v42", 42);

        // Back-to-back: in_valid held through the first conversion.
        wait_ready();
        bin_data = BIN_W'(12);
        in_valid = 1'b1;
        step();
        bin_data = BIN_W'(9876);
        wait_out(lat);
        chk("b2b_lat1", 32'(lat), 32'd15);
        chk_result("b2b1", 12);
        chk("b2b_rdy_on_ovld", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("b2b_busy", 32'(in_ready), 32'd0);
        wait_out(lat);
        chk("b2b_lat2", 32'(lat + 1), 32'd16);
        chk_result("b2b2", 9876);
        watch_quiet("b2b_extra", 20);

        // Busy drop: a pulse during CONV is ignored.
        wait_ready();
        bin_data = BIN_W'(55);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        bin_data = BIN_W'(77);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(lat);
        chk("drop_lat", 32'(lat + 5), 32'd15);
        chk_result("drop", 55);
        watch_quiet("drop_extra", 20);

        // Reset mid-conversion discards the result.
        wait_ready();
        bin_data = BIN_W'(4321);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        chk("mrst_bcd",   32'(bcd_data), 32'h0);
        chk("mrst_blank", 32'(blank),    32'b1110);
        chk("mrst_rdy",   32'(in_ready), 32'd1);
        watch_quiet("mrst_noout", 25);
        run_one("after_rst", 8);

        // Reset on the same edge as an accept: nothing captured.
        bin_data = BIN_W'(321);
        in_valid = 1'b1;
        sys_rst  = 1'b1;
        step();
        in_valid = 1'b0;
        sys_rst  = 1'b0;
        chk("rstacc_rdy", 32'(in_ready), 32'd1);
        watch_quiet("rstacc_noout", 20);

        // Random values across the full input range.
        for (int i = 0; i < 30; i++) begin
            v = int'($urandom_range(0, 16383));
            run_one("rand", v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
